rv32m_div_unit: RTL and testbench



---
 rtl/rv32m_div_unit.sv | 175 +++++++++++++++++
 tb/tb_rv32m_div_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rv32m_div_unit.sv
// ---------------------------------------------------------------------------
// rv32m_div_unit
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU. Sits
// beside the execute-stage ALU; the pipeline raises start, stalls while busy
// is high and takes the answer when done pulses.
//
// Ports:
//   clk     core clock, rising-edge
//   rst_n   asynchronous active-low reset
//   flush   synchronous abort; drops any request, result is kept
//   start   request strobe, accepted in IDLE or DONE only
//   op      00=DIV 01=DIVU 10=REM 11=REMU (funct3[1:0])
//   a, b    dividend / divisor, sampled on accept
//   busy    high while iterating (CALC)
//   done    one-cycle pulse, result valid in the same cycle
//   result  quotient or remainder, held until the next completion or reset
//
// Latency: divide-by-zero and signed overflow finish in 1 cycle; every other
// request spends 32 cycles in CALC and reports done 33 cycles after accept.
// ---------------------------------------------------------------------------
module rv32m_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   rem;       // partial remainder
  logic [XLEN-1:0]   quo;       // dividend bits shift out the top, quotient bits in at the bottom
  logic [XLEN-1:0]   dvsr;      // magnitude of the divisor
  logic              q_neg;
  logic              r_neg;
  logic              is_rem;

  // Two's-complement negate under a flag; negating zero yields zero, so a
  // zero remainder can never turn non-zero here.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                               input logic            neg);
    logic signed [XLEN-1:0] s;
    s = $signed(v);
    return neg ? $unsigned(-s) : v;
  endfunction

  // Magnitude of a signed operand when sgn is set, raw value otherwise.
  // |0x80000000| wraps to 0x80000000, which is still the correct unsigned
  // magnitude for the datapath.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v,
                                          input logic            sgn);
    return cond_neg(v, sgn & v[XLEN-1]);
  endfunction

  // Request decode
  logic            sgn_op;
  logic            div0;
  logic            ovf;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic            accept;

  always_comb begin
    sgn_op      = ~op[0];
    div0        = (b == '0);
    ovf         = sgn_op & (a == SMIN) & (b == '1);
    special     = div0 | ovf;
    special_res = '0;
    if (div0)
      special_res = op[1] ? a : '1;
    else if (ovf)
      special_res = op[1] ? '0 : SMIN;
    accept      = start & (state != CALC);
  end

  // One restoring step: shift the next dividend bit into the remainder,
  // subtract the divisor if it fits. rem < dvsr always holds, so the shifted
  // value fits in XLEN+1 bits and the subtraction's top bit is its sign.
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            fits;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] final_res;

  always_comb begin
    rem_sh    = {rem, quo[XLEN-1]};
    diff      = rem_sh - {1'b0, dvsr};
    fits      = ~diff[XLEN];
    rem_nx    = fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nx    = {quo[XLEN-2:0], fits};
    final_res = is_rem ? cond_neg(rem_nx, r_neg) : cond_neg(quo_nx, q_neg);
  end

  // Control and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      is_rem <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (special) begin
              result <= special_res;
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else begin
              quo    <= mag(a, sgn_op);
              dvsr   <= mag(b, sgn_op);
              rem    <= '0;
              cnt    <= '0;
              q_neg  <= sgn_op & (a[XLEN-1] ^ b[XLEN-1]);
              r_neg  <= sgn_op & a[XLEN-1];
              is_rem <= op[1];
              state  <= CALC;
              busy   <= 1'b1;
              done   <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end

        CALC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            result <= final_res;
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32m_div_unit.sv
module tb_rv32m_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int fails  = 0;
  logic [31:0] last_res;

  rv32m_div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Reference: RISC-V M-extension semantics in plain arithmetic.
  function automatic logic [31:0] ref_res(input logic [1:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
    int sx;
    int sy;
    logic want_rem;
    want_rem = o[1];
    if (y == 32'd0)
      return want_rem ? x : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
        return want_rem ? 32'd0 : 32'h8000_0000;
      sx = x;
      sy = y;
      return want_rem ? 32'(sx % sy) : 32'(sx / sy);
    end
    return want_rem ? (x % y) : (x / y);
  endfunction

  function automatic bit ref_special(input logic [1:0] o,
                                     input logic [31:0] x,
                                     input logic [31:0] y);
    return (y == 32'd0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a request at the current negedge and follow it to done. If noise
  // is non-zero, a divide-by-zero start pulse is injected at that cycle.
  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input int noise, input string tag);
    logic [31:0] exp;
    int elat;
    int lat;
    int bc;
    exp  = ref_res(o, x, y);
    elat = ref_special(o, x, y) ? 1 : 33;
    lat  = -1;
    bc   = 0;
    op = o; a = x; b = y; start = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (noise != 0 && k == noise) begin
        start = 1'b1; op = 2'b00; a = $urandom; b = 32'd0;
      end
      if (busy) bc++;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_res"}, result, exp);
    chk({tag, "_busy"}, 32'(bc), (elat == 1) ? 32'd0 : 32'd32);
    last_res = exp;
  endtask

  initial begin
    int dcnt;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    rst_n = 1'b0; flush = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    last_res = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, chained so each starts in the previous DONE cycle.
    run(2'b00, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
    run(2'b10, 32'hFFFF_FFF9, 32'd2, 0, "rem_m7_2");
    run(2'b11, 32'hFFFF_FFF9, 32'd2, 0, "remu_m7_2");
    run(2'b01, 32'hFFFF_FFFF, 32'd1, 0, "divu_max_1");
    run(2'b01, 32'd100, 32'd7, 5, "divu_100_7_noise");
    run(2'b11, 32'd100, 32'd7, 12, "remu_100_7_noise");
    run(2'b00, 32'h1234_5678, 32'd0, 0, "div_by0");
    run(2'b11, 32'h1234_5678, 32'd0, 0, "remu_by0");
    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    run(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0, "divu_pat");
    run(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, "remu_pat");
    run(2'b00, 32'd20, 32'hFFFF_FFFD, 0, "div_b2b_20_m3");
    run(2'b10, 32'hFFFF_FFF4, 32'd3, 0, "rem_zero_neg");
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);

    // Flush in CALC cycle 10: no done, result retained.
    op = 2'b00; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_done", {31'd0, done}, 32'd0);
    chk("flush_result", result, last_res);
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("flush_no_done", 32'(dcnt), 32'd0);

    // Flush together with start: request dropped.
    op = 2'b01; a = 32'd5; b = 32'd0; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flushstart_busy", {31'd0, busy}, 32'd0);
    chk("flushstart_done", {31'd0, done}, 32'd0);
    chk("flushstart_result", result, last_res);

    // Asynchronous reset in CALC cycle 5.
    op = 2'b00; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(2'b00, 32'd9, 32'd3, 0, "div_9_3_after_rst");
    @(negedge clk);

    // Randomized requests with corner-case operands mixed in.
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15)) ^ ($urandom_range(0, 1) != 0 ? 32'hFFFF_FFFF : 32'd0);
        default: ;
      endcase
      run(ro, ra, rb, 0, $sformatf("rand%0d_op%0d", i, ro));
      if (i % 3 == 0) @(negedge clk);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
